// File: rtl/frac_clk_div.sv
// Fractional clock divider: periods alternate N / N+1 under a phase accumulator.
// Define VERIFY_CNT_EN to build the v_clk_cnt / v_nclk_cnt verification counters.
module frac_clk_div #(
  parameter int CNT_W = 8,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_int,
  input  logic [ACC_W-1:0] div_frac,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err,
  output logic [31:0]      v_clk_cnt,
  output logic [31:0]      v_nclk_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic [CNT_W:0]   ONE = (CNT_W+1)'(1);

  state_t state_q, state_d;
  logic [CNT_W:0] ph_q, ph_d;
  logic [CNT_W:0] len_q, len_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic clk_q, clk_d;
  logic tick_q, tick_d;
  logic [ACC_W:0] sum;
  logic [CNT_W:0] len_new;
  logic [CNT_W:0] ph_inc;
  logic ok, start, busy_w;

  assign cfg_err = (div_int < TWO);
  assign busy_w  = (state_q != IDLE);
  assign ok      = en && !cfg_err;
  // tick_q marks the last cycle of the current period
  assign start   = ok && (state_q == IDLE || tick_q);
  assign sum     = {1'b0, acc_q} + {1'b0, div_frac};
  assign len_new = {1'b0, div_int} + {{CNT_W{1'b0}}, sum[ACC_W]};
  assign ph_inc  = ph_q + ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     if (tick_q) state_d = start ? RUN : IDLE;
               else state_d = en ? RUN : STOP;
      STOP:    if (tick_q) state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ph_d   = '0;
    len_d  = len_q;
    acc_d  = acc_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (start) begin
      acc_d = sum[ACC_W-1:0];
      len_d = len_new;
      clk_d = 1'b1;
    end else if (busy_w && !tick_q) begin
      ph_d   = ph_inc;
      clk_d  = (ph_inc < (len_q >> 1));
      tick_d = (ph_inc == len_q - ONE);
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign busy    = busy_w;

`ifdef VERIFY_CNT_EN
  logic [31:0] vclk_q, vnclk_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vclk_q  <= '0;
      vnclk_q <= '0;
    end else begin
      vclk_q  <= vclk_q + {31'b0, busy_w};
      vnclk_q <= vnclk_q + {31'b0, tick_q};
    end
  end

  assign v_clk_cnt  = vclk_q;
  assign v_nclk_cnt = vnclk_q;
`else
  assign v_clk_cnt  = 32'd0;
  assign v_nclk_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_frac_clk_div.sv
// Directed bench for frac_clk_div.
// Covers reset, integer and fractional ratios, cfg_err, stop and mid-period reset.
module tb_frac_clk_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic [7:0] div_int = 8'd4;
  logic [7:0] div_frac = 8'd0;
  logic clk_out, tick, busy, cfg_err;
  logic [31:0] v_clk_cnt, v_nclk_cnt;

  int n_cmp = 0;
  int n_err = 0;

  frac_clk_div #(.CNT_W(8), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .div_int(div_int), .div_frac(div_frac),
    .clk_out(clk_out), .tick(tick), .busy(busy),
    .cfg_err(cfg_err),
    .v_clk_cnt(v_clk_cnt), .v_nclk_cnt(v_nclk_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vexp(input logic [31:0] v);
`ifdef VERIFY_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Sampled at ph0; returns the period length in cycles.
  task automatic measure(output int n);
    n = 1;
    while (tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int len, cyc, last, nt;

    // reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_cfg", 32'(cfg_err), 32'd0);
    chk("rst_vclk", v_clk_cnt, 32'd0);
    chk("rst_vnclk", v_nclk_cnt, 32'd0);
    rst = 1'b1;

    // 3 + 128/256: periods 3,4,3,4...
    div_int = 8'd3;
    div_frac = 8'd128;
    en = 1'b1;
    step();
    for (int i = 0; i < 70; i++) begin
      if (i < 14) begin
        chk("d35_clk", 32'(clk_out),
            32'(((i % 7) == 0) || ((i % 7) == 3) || ((i % 7) == 4)));
        chk("d35_tick", 32'(tick),
            32'(((i % 7) == 2) || ((i % 7) == 6)));
      end
      step();
    end
    chk("d35_vclk", v_clk_cnt, vexp(32'd70));
    chk("d35_vnclk", v_nclk_cnt, vexp(32'd20));

    // integer divide by 4
    en = 1'b0;
    do_reset();
    div_int = 8'd4;
    div_frac = 8'd0;
    en = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("d4_clk", 32'(clk_out), 32'((i % 4) < 2));
      chk("d4_tick", 32'(tick), 32'((i % 4) == 3));
      step();
    end

    // 5 + 64/256: 5,5,5,6 repeating, 84 cycles per 16 ticks
    en = 1'b0;
    do_reset();
    div_int = 8'd5;
    div_frac = 8'd64;
    en = 1'b1;
    step();
    cyc = 1;
    last = 0;
    nt = 0;
    while (nt < 16 && cyc < 200) begin
      if (tick === 1'b1) begin
        chk("d5q_len", 32'(cyc - last), ((nt % 4) == 3) ? 32'd6 : 32'd5);
        last = cyc;
        nt++;
      end
      if (nt < 16) begin
        step();
        cyc++;
      end
    end
    chk("d5q_total", 32'(last), 32'd84);

    // cfg_err blocks start; div_int=2 starts 1 high / 1 low
    en = 1'b0;
    do_reset();
    div_int = 8'd1;
    div_frac = 8'd0;
    en = 1'b1;
    step();
    chk("cfg_err", 32'(cfg_err), 32'd1);
    chk("cfg_busy", 32'(busy), 32'd0);
    chk("cfg_clk", 32'(clk_out), 32'd0);
    div_int = 8'd2;
    step();
    chk("d2_busy", 32'(busy), 32'd1);
    chk("d2_clk0", 32'(clk_out), 32'd1);
    step();
    chk("d2_clk1", 32'(clk_out), 32'd0);
    chk("d2_tick", 32'(tick), 32'd1);
    step();
    chk("d2_clk2", 32'(clk_out), 32'd1);

    // graceful stop at ph1 of a len-5 period, then acc continues
    en = 1'b0;
    do_reset();
    div_int = 8'd5;
    div_frac = 8'd128;
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    step();
    chk("stop_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("stop_tick", 32'(tick), 32'd1);
    step();
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_clk", 32'(clk_out), 32'd0);
    en = 1'b1;
    step();
    measure(len);
    chk("restart_len", 32'(len), 32'd6);

    // reset at ph2 of the next period
    step();
    step();
    step();
    rst = 1'b0;
    step();
    chk("mrst_clk", 32'(clk_out), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_tick", 32'(tick), 32'd0);
    chk("mrst_vclk", v_clk_cnt, 32'd0);
    chk("mrst_vnclk", v_nclk_cnt, 32'd0);
    rst = 1'b1;
    step();
    chk("mrst_start", 32'(clk_out), 32'd1);
    measure(len);
    chk("mrst_len", 32'(len), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
